// File: rtl/or_out_collector.sv
// Collects OR gate result words into a circular FIFO with a fall-through head from storage.
// Keeps a sticky drop flag and a saturating count of accepted nonzero results.
module or_out_collector #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              ones_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic [15:0]      r_ones_cnt;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_nonzero;
  logic w_flush;

  always_comb begin
    w_full    = (r_level == FULL_LEVEL);
    w_empty   = (r_level == '0);
    w_pop     = !w_empty && out_ready;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    w_push    = in_valid && (!w_full || w_pop);
    w_drop    = in_valid && !w_push;
    w_nonzero = |in_data;
    w_flush   = rst || clr;
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_level <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_ones_cnt <= '0;
    end else if (w_push && w_nonzero && (r_ones_cnt != 16'hFFFF)) begin
      r_ones_cnt <= r_ones_cnt + 16'd1;
    end
  end

  // Storage is never cleared; only the pointers and level define its valid contents.
  always_ff @(posedge clk) begin
    if (w_push && !w_flush) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = r_mem[r_rptr];
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign ones_cnt  = r_ones_cnt;

endmodule
